// File: rtl/exc_commit_pkg.sv
// Shared ExcCode values, Status bit index and enum types for the commit-stage exception logic.
package exc_commit_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam int STATUS_BEV = 22;

  typedef enum logic [1:0] {
    BADV_NONE = 2'd0,
    BADV_PC   = 2'd1,
    BADV_ADDR = 2'd2
  } badv_sel_t;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/exc_commit_if.sv
// Commit-stage bundle: instruction info in, CP0 report / flush / fetch redirect out.
// exc_tr exists only when EXC_TRAP_EN is defined.
interface exc_commit_if;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic [31:0] commit_badva;
  logic        exc_if_adel;
  logic        exc_ri;
  logic        exc_ov;
`ifdef EXC_TRAP_EN
  logic        exc_tr;
`endif
  logic        exc_sys;
  logic        exc_bp;
  logic        exc_mem_adel;
  logic        exc_mem_ades;
  logic        commit_eret;
  logic        int_response;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        exc_valid;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  // Pipeline/fetch/CP0 environment side.
  modport master (
    output commit_valid, commit_pc, commit_bd, commit_badva,
           exc_if_adel, exc_ri, exc_ov,
`ifdef EXC_TRAP_EN
           exc_tr,
`endif
           exc_sys, exc_bp, exc_mem_adel, exc_mem_ades,
           commit_eret, int_response, cp0_status, cp0_epc, redirect_ready,
    input  exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr, exc_eret,
           flush, redirect_valid, redirect_pc
  );

  // Exception initiator side.
  modport slave (
    input  commit_valid, commit_pc, commit_bd, commit_badva,
           exc_if_adel, exc_ri, exc_ov,
`ifdef EXC_TRAP_EN
           exc_tr,
`endif
           exc_sys, exc_bp, exc_mem_adel, exc_mem_ades,
           commit_eret, int_response, cp0_status, cp0_epc, redirect_ready,
    output exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr, exc_eret,
           flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_commit_prio_enc.sv
// Fixed-priority encoder: exception flags -> {hit, excode, badvaddr source}.
// The Tr input and its priority slot exist only when EXC_TRAP_EN is defined.
module exc_prio_enc
  import exc_commit_pkg::*;
(
  input  logic      int_response,
  input  logic      if_adel,
  input  logic      ri,
  input  logic      ov,
`ifdef EXC_TRAP_EN
  input  logic      tr,
`endif
  input  logic      sys,
  input  logic      bp,
  input  logic      mem_adel,
  input  logic      mem_ades,
  output logic      hit,
  output logic [4:0] excode,
  output badv_sel_t badv_sel
);

  always_comb begin
    hit      = 1'b1;
    excode   = EXC_INT;
    badv_sel = BADV_NONE;
    if (int_response) begin
      excode = EXC_INT;
    end else if (if_adel) begin
      excode   = EXC_ADEL;
      badv_sel = BADV_PC;
    end else if (ri) begin
      excode = EXC_RI;
    end else if (ov) begin
      excode = EXC_OV;
`ifdef EXC_TRAP_EN
    end else if (tr) begin
      excode = EXC_TR;
`endif
    end else if (sys) begin
      excode = EXC_SYS;
    end else if (bp) begin
      excode = EXC_BP;
    end else if (mem_adel) begin
      excode   = EXC_ADEL;
      badv_sel = BADV_ADDR;
    end else if (mem_ades) begin
      excode   = EXC_ADES;
      badv_sel = BADV_ADDR;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_commit.sv
// Commit-stage exception/ERET initiator: CP0 report, pipeline flush and held fetch redirect.
// Optional trap exception enabled by defining EXC_TRAP_EN.
module exc_commit
  import exc_commit_pkg::*;
#(
  parameter logic [31:0] VEC_NORMAL = 32'h8000_0180,
  parameter logic [31:0] VEC_BEV    = 32'hBFC0_0380
) (
  input logic         clk,
  input logic         reset,
  exc_commit_if.slave bus
);

  state_t      state;
  logic        hit;
  logic [4:0]  excode;
  badv_sel_t   badv_sel;
  logic        take;
  logic [31:0] target;
  logic [31:0] badv;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  exc_prio_enc u_prio (
    .int_response (bus.int_response),
    .if_adel      (bus.exc_if_adel),
    .ri           (bus.exc_ri),
    .ov           (bus.exc_ov),
`ifdef EXC_TRAP_EN
    .tr           (bus.exc_tr),
`endif
    .sys          (bus.exc_sys),
    .bp           (bus.exc_bp),
    .mem_adel     (bus.exc_mem_adel),
    .mem_ades     (bus.exc_mem_ades),
    .hit          (hit),
    .excode       (excode),
    .badv_sel     (badv_sel)
  );

  // Only one report per redirect: a pending redirect blocks any new take.
  assign take = bus.commit_valid && (state == IDLE) && (hit || bus.commit_eret);

  always_comb begin
    case (badv_sel)
      BADV_PC:   badv = bus.commit_pc;
      BADV_ADDR: badv = bus.commit_badva;
      default:   badv = 32'd0;
    endcase
  end

  assign target = hit ? (bus.cp0_status[STATUS_BEV] ? VEC_BEV : VEC_NORMAL) : bus.cp0_epc;

  assign bus.exc_valid    = take;
  assign bus.exc_excode   = (take && hit) ? excode : 5'd0;
  assign bus.exc_bd       = take && bus.commit_bd;
  assign bus.exc_epc      = !take ? 32'd0 :
                            (bus.commit_bd ? bus.commit_pc - 32'd4 : bus.commit_pc);
  assign bus.exc_badvaddr = take ? badv : 32'd0;
  assign bus.exc_eret     = take && !hit;
  assign bus.flush        = take || (state == REDIRECT);

  // Redirect stage: target captured at the take edge, held until fetch accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state            <= REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= target;
          end
        end
        REDIRECT: begin
          if (bus.redirect_ready) begin
            state            <= IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_commit.sv
// Scoreboard bench for exc_commit: directed commits push expected reports/targets; monitors pop and compare.
module tb_exc_commit;
  import exc_commit_pkg::*;

  typedef struct packed {
    logic [4:0]  code;
    logic        bd;
    logic [31:0] epc;
    logic [31:0] badv;
    logic        eret;
  } exc_t;

  // flag vector order: {if_adel, ri, ov, sys, bp, mem_adel, mem_ades}
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_IFA  = 7'b1000000;
  localparam logic [6:0] F_RI   = 7'b0100000;
  localparam logic [6:0] F_OV   = 7'b0010000;
  localparam logic [6:0] F_SYS  = 7'b0001000;
  localparam logic [6:0] F_BP   = 7'b0000100;
  localparam logic [6:0] F_MADS = 7'b0000001;
  localparam logic [31:0] BEV1  = 32'h0040_0000;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exc_t exc_q[$];
  logic [31:0] rd_q[$];

  exc_commit_if bus ();

  exc_commit #(
    .VEC_NORMAL (32'h8000_0180),
    .VEC_BEV    (32'hBFC0_0380)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_commit();
    bus.commit_valid = 1'b0;
    bus.commit_bd    = 1'b0;
    bus.commit_pc    = 32'd0;
    bus.commit_badva = 32'd0;
    bus.exc_if_adel  = 1'b0;
    bus.exc_ri       = 1'b0;
    bus.exc_ov       = 1'b0;
`ifdef EXC_TRAP_EN
    bus.exc_tr       = 1'b0;
`endif
    bus.exc_sys      = 1'b0;
    bus.exc_bp       = 1'b0;
    bus.exc_mem_adel = 1'b0;
    bus.exc_mem_ades = 1'b0;
    bus.commit_eret  = 1'b0;
    bus.int_response = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic bd, input logic [31:0] badva,
                       input logic [6:0] fl, input logic intr, input logic eret);
    bus.commit_valid = 1'b1;
    bus.commit_pc    = pc;
    bus.commit_bd    = bd;
    bus.commit_badva = badva;
    {bus.exc_if_adel, bus.exc_ri, bus.exc_ov, bus.exc_sys,
     bus.exc_bp, bus.exc_mem_adel, bus.exc_mem_ades} = fl;
    bus.int_response = intr;
    bus.commit_eret  = eret;
  endtask

  // One committing instruction that must be taken; expectations go to the scoreboard.
  task automatic do_commit(input logic [31:0] pc, input logic bd, input logic [31:0] badva,
                           input logic [6:0] fl, input logic intr, input logic eret,
                           input logic [31:0] status, input logic [31:0] epc,
                           input exc_t exp, input logic [31:0] tgt);
    bus.cp0_status = status;
    bus.cp0_epc    = epc;
    drive(pc, bd, badva, fl, intr, eret);
    exc_q.push_back(exp);
    rd_q.push_back(tgt);
    @(negedge clk);
    chk("flush_take", {31'd0, bus.flush}, 32'd1);
    @(posedge clk); #1;
    clear_commit();
  endtask

  // Hold the redirect for n cycles, then let fetch accept it.
  task automatic redirect_wait(input int n, input logic [31:0] tgt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rv_hold",    {31'd0, bus.redirect_valid}, 32'd1);
      chk("rpc_hold",   bus.redirect_pc, tgt);
      chk("flush_hold", {31'd0, bus.flush}, 32'd1);
      chk("no_exc",     {31'd0, bus.exc_valid}, 32'd0);
      @(posedge clk); #1;
    end
    bus.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bus.redirect_ready = 1'b0;
    @(negedge clk);
    chk("rv_drop",    {31'd0, bus.redirect_valid}, 32'd0);
    chk("flush_drop", {31'd0, bus.flush}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Report monitor and redirect-handshake monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.exc_valid) begin
        if (exc_q.size() == 0) begin
          chk("unexpected_exc_valid", 32'd1, 32'd0);
        end else begin
          exc_t e;
          e = exc_q.pop_front();
          chk("excode",   {27'd0, bus.exc_excode}, {27'd0, e.code});
          chk("bd",       {31'd0, bus.exc_bd}, {31'd0, e.bd});
          chk("epc",      bus.exc_epc, e.epc);
          chk("badvaddr", bus.exc_badvaddr, e.badv);
          chk("eret",     {31'd0, bus.exc_eret}, {31'd0, e.eret});
        end
      end
      if (bus.redirect_valid && bus.redirect_ready) begin
        if (rd_q.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
        else chk("redirect_pc", bus.redirect_pc, rd_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear_commit();
    bus.cp0_status     = 32'd0;
    bus.cp0_epc        = 32'd0;
    bus.redirect_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rv",    {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_rpc",   bus.redirect_pc, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_exc",   {31'd0, bus.exc_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Plain instruction: nothing taken.
    drive(32'h8000_0800, 1'b0, 32'd0, F_NONE, 1'b0, 1'b0);
    @(negedge clk);
    chk("plain_exc",   {31'd0, bus.exc_valid}, 32'd0);
    chk("plain_flush", {31'd0, bus.flush}, 32'd0);
    @(posedge clk); #1;
    clear_commit();

    // redirect_ready while idle is ignored.
    bus.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bus.redirect_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready_rv", {31'd0, bus.redirect_valid}, 32'd0);
    @(posedge clk); #1;

    // Overflow, BEV=0.
    do_commit(32'h8000_1000, 1'b0, 32'd0, F_OV, 1'b0, 1'b0, 32'd0, 32'd0,
              '{code: 5'd12, bd: 1'b0, epc: 32'h8000_1000, badv: 32'd0, eret: 1'b0},
              32'h8000_0180);
    redirect_wait(3, 32'h8000_0180);

    // Store address error in a delay slot.
    do_commit(32'h8000_2004, 1'b1, 32'h0000_1003, F_MADS, 1'b0, 1'b0, 32'd0, 32'd0,
              '{code: 5'd5, bd: 1'b1, epc: 32'h8000_2000, badv: 32'h0000_1003, eret: 1'b0},
              32'h8000_0180);
    redirect_wait(1, 32'h8000_0180);

    // Interrupt outranks RI, BEV=1.
    do_commit(32'h8000_4000, 1'b0, 32'd0, F_RI, 1'b1, 1'b0, BEV1, 32'd0,
              '{code: 5'd0, bd: 1'b0, epc: 32'h8000_4000, badv: 32'd0, eret: 1'b0},
              32'hBFC0_0380);
    redirect_wait(1, 32'hBFC0_0380);

    // ERET to EPC.
    do_commit(32'h8000_5000, 1'b0, 32'd0, F_NONE, 1'b0, 1'b1, 32'd0, 32'h8000_3000,
              '{code: 5'd0, bd: 1'b0, epc: 32'h8000_5000, badv: 32'd0, eret: 1'b1},
              32'h8000_3000);
    redirect_wait(1, 32'h8000_3000);

    // Fetch AdEL outranks ERET.
    do_commit(32'h8000_6003, 1'b0, 32'h0000_0044, F_IFA, 1'b0, 1'b1, 32'd0, 32'h8000_3000,
              '{code: 5'd4, bd: 1'b0, epc: 32'h8000_6003, badv: 32'h8000_6003, eret: 1'b0},
              32'h8000_0180);
    redirect_wait(1, 32'h8000_0180);

    // Syscall outranks break; pc 0 in a delay slot wraps the EPC.
    do_commit(32'h0000_0000, 1'b1, 32'd0, F_SYS | F_BP, 1'b0, 1'b0, 32'd0, 32'd0,
              '{code: 5'd8, bd: 1'b1, epc: 32'hFFFF_FFFC, badv: 32'd0, eret: 1'b0},
              32'h8000_0180);
    redirect_wait(1, 32'h8000_0180);

`ifdef EXC_TRAP_EN
    bus.exc_tr = 1'b1;
    do_commit(32'h8000_7000, 1'b0, 32'd0, F_SYS, 1'b0, 1'b0, 32'd0, 32'd0,
              '{code: 5'd13, bd: 1'b0, epc: 32'h8000_7000, badv: 32'd0, eret: 1'b0},
              32'h8000_0180);
    redirect_wait(1, 32'h8000_0180);
`endif

    // Interrupt stays pending while the redirect is stalled; then reset abandons it.
    do_commit(32'h8000_8000, 1'b0, 32'd0, F_NONE, 1'b1, 1'b0, 32'd0, 32'd0,
              '{code: 5'd0, bd: 1'b0, epc: 32'h8000_8000, badv: 32'd0, eret: 1'b0},
              32'h8000_0180);
    drive(32'h8000_8004, 1'b0, 32'd0, F_OV, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rv",    {31'd0, bus.redirect_valid}, 32'd1);
      chk("stall_rpc",   bus.redirect_pc, 32'h8000_0180);
      chk("stall_flush", {31'd0, bus.flush}, 32'd1);
      @(posedge clk); #1;
    end
    clear_commit();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abandon_rv",    {31'd0, bus.redirect_valid}, 32'd0);
    chk("abandon_flush", {31'd0, bus.flush}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd_q.delete();

    repeat (2) @(posedge clk);
    chk("exc_q_empty", exc_q.size(), 32'd0);
    chk("rd_q_empty",  rd_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
